mem_port_arbiter: RTL and testbench

//   Shares one single-port data RAM between the CPU datapath (MM/MW data path) and an IO/loader

---
 rtl/mem_port_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port data RAM between the CPU datapath and
//               an IO/loader requester. Each access is sequenced by a 4-state
//               FSM (IDLE -> ACCESS -> [WAIT] -> DONE). Simultaneous requests
//               are resolved round-robin, and cpu_stall holds the CPU control
//               state while its access is outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 16,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    // CPU requester
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_stall,
    // IO / loader requester
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic [DATA_W-1:0] io_rdata,
    output logic              io_done,
    // RAM side
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    // Arbitration status
    output logic              owner
);

    // FSM encoding
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_WAIT   = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    // Requester identifiers used for owner / last_grant
    localparam logic c_SEL_CPU = 1'b0;
    localparam logic c_SEL_IO  = 1'b1;

    // Wait counter counts READ_LAT-1 down to 0; at least one bit wide
    localparam int              c_CNT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAT_M1 = c_CNT_W'(READ_LAT - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic               r_last_grant;
    logic               r_owner;
    logic               r_we_q;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic [DATA_W-1:0]  r_cpu_rdata;
    logic [DATA_W-1:0]  r_io_rdata;
    logic [c_CNT_W-1:0] r_wait_cnt;

    logic               w_grant_valid;
    logic               w_grant_sel;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic               w_sel_we;
    logic               w_wait_last;

    // Round-robin grant decision: a lone requester wins outright, on a
    // conflict the requester that was not served last time wins.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_sel   = c_SEL_CPU;
        if (cpu_req && io_req) begin
            w_grant_valid = 1'b1;
            w_grant_sel   = ~r_last_grant;
        end else if (cpu_req) begin
            w_grant_valid = 1'b1;
            w_grant_sel   = c_SEL_CPU;
        end else if (io_req) begin
            w_grant_valid = 1'b1;
            w_grant_sel   = c_SEL_IO;
        end
    end

    // Request mux feeding the latched RAM command
    always_comb begin
        w_sel_addr  = cpu_addr;
        w_sel_wdata = cpu_wdata;
        w_sel_we    = cpu_we;
        if (w_grant_sel == c_SEL_IO) begin
            w_sel_addr  = io_addr;
            w_sel_wdata = io_wdata;
            w_sel_we    = io_we;
        end
    end

    assign w_wait_last = (r_wait_cnt == '0);

    // Next-state logic for the access sequencer
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_grant_valid) begin
                    w_next_state = c_ST_ACCESS;
                end
            end
            c_ST_ACCESS: begin
                w_next_state = r_we_q ? c_ST_DONE : c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (w_wait_last) begin
                    w_next_state = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Command latch, arbitration history and wait counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_we_q       <= 1'b0;
            r_owner      <= c_SEL_CPU;
            r_last_grant <= c_SEL_IO;
            r_wait_cnt   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_mem_addr   <= w_sel_addr;
                        r_mem_wdata  <= w_sel_wdata;
                        r_we_q       <= w_sel_we;
                        r_owner      <= w_grant_sel;
                        r_last_grant <= w_grant_sel;
                    end
                end
                c_ST_ACCESS: begin
                    r_wait_cnt <= c_LAT_M1;
                end
                c_ST_WAIT: begin
                    if (!w_wait_last) begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Read-data capture on the final WAIT cycle; only the owner's register moves
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_rdata <= '0;
            r_io_rdata  <= '0;
        end else if (r_state == c_ST_WAIT && w_wait_last) begin
            if (r_owner == c_SEL_IO) begin
                r_io_rdata <= mem_rdata;
            end else begin
                r_cpu_rdata <= mem_rdata;
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = (r_state == c_ST_ACCESS) && r_we_q;
    assign owner     = r_owner;
    assign cpu_rdata = r_cpu_rdata;
    assign io_rdata  = r_io_rdata;
    assign cpu_done  = (r_state == c_ST_DONE) && (r_owner == c_SEL_CPU);
    assign io_done   = (r_state == c_ST_DONE) && (r_owner == c_SEL_IO);
    assign cpu_stall = cpu_req && !cpu_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter. One
//               instance runs with READ_LAT=1, a second with READ_LAT=3, each
//               attached to a small behavioural RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int c_AW = 6;
    localparam int c_DW = 16;

    logic clk;
    logic reset;

    int checks;
    int failures;

    // ---------------- instance with READ_LAT = 1 ----------------
    logic            cpu_req, cpu_we, io_req, io_we;
    logic [c_AW-1:0] cpu_addr, io_addr, mem_addr;
    logic [c_DW-1:0] cpu_wdata, io_wdata, cpu_rdata, io_rdata, mem_wdata, mem_rdata;
    logic            cpu_done, cpu_stall, io_done, mem_we, owner;

    mem_port_arbiter #(.ADDR_W(c_AW), .DATA_W(c_DW), .READ_LAT(1)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_done(io_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .owner(owner)
    );

    // RAM model: synchronous write, one-cycle registered read
    logic [c_DW-1:0] ram [64];
    logic [c_DW-1:0] r_rd1;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        r_rd1 <= ram[mem_addr];
    end
    assign mem_rdata = r_rd1;

    // ---------------- instance with READ_LAT = 3 ----------------
    logic            c3_req, c3_we, i3_req, i3_we;
    logic [c_AW-1:0] c3_addr, i3_addr, m3_addr;
    logic [c_DW-1:0] c3_wdata, i3_wdata, c3_rdata, i3_rdata, m3_wdata, m3_rdata;
    logic            c3_done, c3_stall, i3_done, m3_we, owner3;

    mem_port_arbiter #(.ADDR_W(c_AW), .DATA_W(c_DW), .READ_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
        .cpu_rdata(c3_rdata), .cpu_done(c3_done), .cpu_stall(c3_stall),
        .io_req(i3_req), .io_we(i3_we), .io_addr(i3_addr), .io_wdata(i3_wdata),
        .io_rdata(i3_rdata), .io_done(i3_done),
        .mem_addr(m3_addr), .mem_wdata(m3_wdata), .mem_we(m3_we), .mem_rdata(m3_rdata),
        .owner(owner3)
    );

    // RAM model with a three-stage read pipeline
    logic [c_DW-1:0] ram3 [64];
    logic [c_DW-1:0] r_p3a, r_p3b, r_p3c;
    always @(posedge clk) begin
        if (m3_we) ram3[m3_addr] <= m3_wdata;
        r_p3a <= ram3[m3_addr];
        r_p3b <= r_p3a;
        r_p3c <= r_p3b;
    end
    assign m3_rdata = r_p3c;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    int cyc;

    initial begin
        checks   = 0;
        failures = 0;
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        io_req  = 0; io_we  = 0; io_addr  = '0; io_wdata  = '0;
        c3_req  = 0; c3_we  = 0; c3_addr  = '0; c3_wdata  = '0;
        i3_req  = 0; i3_we  = 0; i3_addr  = '0; i3_wdata  = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
        check("rst_io_rdata",  32'(io_rdata),  32'h0);
        check("rst_mem_addr",  32'(mem_addr),  32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        check("rst_mem_we",    32'(mem_we),    32'h0);
        check("rst_dones",     32'({cpu_done, io_done}), 32'h0);
        check("rst_owner",     32'(owner),     32'h0);

        // CPU write 0x05 <= 0xBEEF
        cpu_req = 1; cpu_we = 1; cpu_addr = 6'h05; cpu_wdata = 16'hBEEF;
        #1 check("wr_stall_n", 32'(cpu_stall), 32'h1);
        tick();                                   // n+1 ACCESS
        cpu_addr = 6'h00; cpu_wdata = 16'h0000;   // command must already be latched
        #1;
        check("wr_mem_we",    32'(mem_we),    32'h1);
        check("wr_mem_addr",  32'(mem_addr),  32'h05);
        check("wr_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        check("wr_stall_n1",  32'(cpu_stall), 32'h1);
        check("wr_done_n1",   32'(cpu_done),  32'h0);
        tick();                                   // n+2 DONE
        check("wr_done_n2",   32'(cpu_done),  32'h1);
        check("wr_stall_n2",  32'(cpu_stall), 32'h0);
        check("wr_we_n2",     32'(mem_we),    32'h0);
        cpu_req = 0;
        tick();
        check("wr_done_idle", 32'(cpu_done),  32'h0);

        // CPU read 0x05, READ_LAT=1
        cpu_req = 1; cpu_we = 0; cpu_addr = 6'h05;
        tick();                                   // n+1 ACCESS
        check("rd_we_access", 32'(mem_we),    32'h0);
        tick();                                   // n+2 WAIT
        check("rd_done_n2",   32'(cpu_done),  32'h0);
        check("rd_addr_hold", 32'(mem_addr),  32'h05);
        tick();                                   // n+3 DONE
        check("rd_done_n3",   32'(cpu_done),  32'h1);
        check("rd_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);
        check("rd_io_rdata",  32'(io_rdata),  32'h0);
        cpu_req = 0;
        tick();

        // IO write 0x3F <= 0x1234 to seed the RAM
        io_req = 1; io_we = 1; io_addr = 6'h3F; io_wdata = 16'h1234;
        tick();
        check("iow_mem_we",  32'(mem_we),  32'h1);
        check("iow_owner",   32'(owner),   32'h1);
        tick();
        check("iow_io_done", 32'(io_done), 32'h1);
        check("iow_io_rdata_kept", 32'(io_rdata), 32'h0);
        io_req = 0;
        tick();

        // IO read max address with a CPU write arriving during the transaction
        io_req = 1; io_we = 0; io_addr = 6'h3F;
        tick();                                   // n+1 ACCESS
        cpu_req = 1; cpu_we = 1; cpu_addr = 6'h10; cpu_wdata = 16'h5555;
        #1;
        check("ior_mem_addr", 32'(mem_addr), 32'h3F);
        check("ior_owner",    32'(owner),    32'h1);
        tick();                                   // n+2 WAIT
        check("ior_cpu_stall", 32'(cpu_stall), 32'h1);
        tick();                                   // n+3 DONE
        check("ior_io_done",  32'(io_done),   32'h1);
        check("ior_io_rdata", 32'(io_rdata),  32'h1234);
        check("ior_cpu_keep", 32'(cpu_rdata), 32'hBEEF);
        check("ior_cpu_done", 32'(cpu_done),  32'h0);
        io_req = 0;
        tick();                                   // IDLE, CPU sampled
        check("pend_we_idle", 32'(mem_we), 32'h0);
        tick();                                   // ACCESS for CPU
        check("pend_mem_we",   32'(mem_we),   32'h1);
        check("pend_mem_addr", 32'(mem_addr), 32'h10);
        check("pend_owner",    32'(owner),    32'h0);
        tick();
        check("pend_cpu_done", 32'(cpu_done), 32'h1);
        cpu_req = 0;
        tick();

        // Reset asserted during WAIT of a CPU read
        cpu_req = 1; cpu_we = 0; cpu_addr = 6'h3F;
        tick();                                   // ACCESS
        tick();                                   // WAIT
        reset = 1; cpu_req = 0;
        tick();
        check("mrst_cpu_done", 32'(cpu_done),  32'h0);
        check("mrst_mem_we",   32'(mem_we),    32'h0);
        check("mrst_cpu_rdata",32'(cpu_rdata), 32'h0);
        tick();
        reset = 0;
        check("mrst_io_rdata", 32'(io_rdata),  32'h0);
        check("mrst_mem_addr", 32'(mem_addr),  32'h0);
        check("mrst_owner",    32'(owner),     32'h0);
        tick();
        check("mrst_idle_done", 32'({cpu_done, io_done}), 32'h0);

        // Conflict: both requesters held high, expect CPU,IO,CPU,IO
        cpu_req = 1; cpu_we = 1; cpu_addr = 6'h01; cpu_wdata = 16'h1111;
        io_req  = 1; io_we  = 1; io_addr  = 6'h02; io_wdata  = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            logic exp_io;
            exp_io = (i % 2) == 1;
            tick();                               // ACCESS
            check($sformatf("rr%0d_owner", i), 32'(owner), 32'(exp_io));
            check($sformatf("rr%0d_addr", i),  32'(mem_addr), exp_io ? 32'h02 : 32'h01);
            tick();                               // DONE
            check($sformatf("rr%0d_dones", i), 32'({cpu_done, io_done}),
                  exp_io ? 32'h1 : 32'h2);
            if (i == 3) begin
                cpu_req = 0; io_req = 0;
            end
            tick();                               // IDLE
            check($sformatf("rr%0d_idle", i), 32'({cpu_done, io_done, mem_we}), 32'h0);
        end

        // CPU drops req during ACCESS: transaction still completes once
        cpu_req = 1; cpu_we = 1; cpu_addr = 6'h07; cpu_wdata = 16'h7777;
        tick();
        cpu_req = 0;
        #1 check("drop_mem_we", 32'(mem_we), 32'h1);
        tick();
        check("drop_cpu_done", 32'(cpu_done), 32'h1);
        check("drop_stall",    32'(cpu_stall), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("drop_quiet%0d", i), 32'({cpu_done, mem_we}), 32'h0);
        end
        check("drop_ram", 32'(ram[7]), 32'h7777);

        // READ_LAT=3 instance: write then read, done expected at n+5
        c3_req = 1; c3_we = 1; c3_addr = 6'h05; c3_wdata = 16'hBEEF;
        tick();
        tick();
        check("l3_wr_done", 32'(c3_done), 32'h1);
        c3_req = 0;
        tick();
        c3_req = 1; c3_we = 0;
        cyc = 0;
        while (!c3_done && cyc < 20) begin
            tick();
            cyc++;
        end
        check("l3_rd_latency", 32'(cyc), 32'd5);
        check("l3_rd_rdata",   32'(c3_rdata), 32'hBEEF);
        check("l3_io_rdata",   32'(i3_rdata), 32'h0);
        c3_req = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
